// File: rtl/write_port_scheduler.sv
// rtl/write_port_scheduler.sv - priority + round-robin write port arbiter with one-cycle release gap
// Optional grant watchdog is enabled by defining WRITE_SCHED_TIMEOUT_EN.
module write_port_scheduler #(
  parameter int num_of_ports   = 16,
  parameter int priority_width = 3,
  parameter int des_port_width = 4,
  parameter int timeout_cycles = 1024
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [num_of_ports-1:0]              ready,
  input  logic [num_of_ports-1:0]              eop,
  input  logic [num_of_ports*priority_width-1:0] priority_in,
  input  logic [num_of_ports*des_port_width-1:0] des_port_in,
  output logic [num_of_ports-1:0]              grant,
  output logic [3:0]                           select,
  output logic [des_port_width-1:0]            grant_des_port,
  output logic                                 busy,
  output logic                                 abort
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t                    state_q, state_d;
  logic [3:0]                last_ptr, last_ptr_d;
  logic [num_of_ports-1:0]   grant_d;
  logic [3:0]                select_d;
  logic [des_port_width-1:0] des_d;
  logic                      busy_d, abort_d;

  logic                      win_found;
  logic [3:0]                win_idx;
  logic [priority_width-1:0] win_prio;
  logic [3:0]                scan_idx;
  logic [priority_width-1:0] scan_prio;
  logic                      tmo;

  // The watchdog compares against timeout_cycles-1, so a limit below 2 is meaningless.
  if (timeout_cycles < 2) begin : g_timeout_check
    $error("write_port_scheduler: timeout_cycles must be at least 2");
  end

  // Scan starts just after the last served port; strict '>' keeps the first hit among equal priorities.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_prio  = '0;
    scan_idx  = '0;
    scan_prio = '0;
    for (int i = 0; i < num_of_ports; i++) begin
      scan_idx  = last_ptr + 4'd1 + 4'(i);
      scan_prio = priority_in[scan_idx*priority_width +: priority_width];
      if (ready[scan_idx] && (!win_found || scan_prio > win_prio)) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
        win_prio  = scan_prio;
      end
    end
  end

`ifdef WRITE_SCHED_TIMEOUT_EN
  localparam int cnt_w = $clog2(timeout_cycles);
  logic [cnt_w-1:0] tmo_cnt;

  always_ff @(posedge clk) begin
    if (rst || state_q != GRANT) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + cnt_w'(1);
    end
  end

  assign tmo = (state_q == GRANT) && (tmo_cnt == cnt_w'(timeout_cycles - 1));
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant;
    select_d   = select;
    des_d      = grant_des_port;
    busy_d     = busy;
    abort_d    = 1'b0;
    last_ptr_d = last_ptr;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d  = GRANT;
          grant_d  = {{(num_of_ports-1){1'b0}}, 1'b1} << win_idx;
          select_d = win_idx;
          des_d    = des_port_in[win_idx*des_port_width +: des_port_width];
          busy_d   = 1'b1;
        end
      end
      GRANT: begin
        // eop wins over a simultaneous ready drop: that is a clean end of packet.
        if (eop[select] || !ready[select] || tmo) begin
          state_d    = GAP;
          grant_d    = '0;
          busy_d     = 1'b0;
          last_ptr_d = select;
          abort_d    = !eop[select];
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      grant          <= '0;
      select         <= '0;
      grant_des_port <= '0;
      busy           <= 1'b0;
      abort          <= 1'b0;
      last_ptr       <= 4'hF;
    end else begin
      state_q        <= state_d;
      grant          <= grant_d;
      select         <= select_d;
      grant_des_port <= des_d;
      busy           <= busy_d;
      abort          <= abort_d;
      last_ptr       <= last_ptr_d;
    end
  end

endmodule

// File: tb/tb_write_port_scheduler.sv
// tb/tb_write_port_scheduler.sv - scoreboard bench for write_port_scheduler
// Honours WRITE_SCHED_TIMEOUT_EN for the watchdog scenario.
module tb_write_port_scheduler;

  logic        clk;
  logic        rst;
  logic [15:0] ready;
  logic [15:0] eop;
  logic [47:0] priority_in;
  logic [63:0] des_port_in;
  logic [15:0] grant;
  logic [3:0]  select;
  logic [3:0]  grant_des_port;
  logic        busy;
  logic        abort;

  write_port_scheduler #(
    .num_of_ports  (16),
    .priority_width(3),
    .des_port_width(4),
    .timeout_cycles(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ready         (ready),
    .eop           (eop),
    .priority_in   (priority_in),
    .des_port_in   (des_port_in),
    .grant         (grant),
    .select        (select),
    .grant_des_port(grant_des_port),
    .busy          (busy),
    .abort         (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] sel;
    logic [3:0] des;
    bit         ab;
    logic [3:0] sel_after;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   model_last = 15;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Highest priority wins; ties go to the smallest circular distance past the last served port.
  function automatic int ref_pick(input logic [15:0] mask, input logic [47:0] pv);
    int best = -1;
    int bp   = -1;
    int bd   = 99;
    for (int p = 0; p < 16; p++) begin
      if (mask[p]) begin
        int pr;
        int d;
        pr = int'(pv[p*3 +: 3]);
        d  = (p - model_last - 1 + 32) % 16;
        if (pr > bp || (pr == bp && d < bd)) begin
          best = p;
          bp   = pr;
          bd   = d;
        end
      end
    end
    return best;
  endfunction

  function automatic exp_t mk_exp(input int w, input logic [63:0] dv, input bit ab);
    exp_t e;
    e.sel       = 4'(w);
    e.des       = dv[w*4 +: 4];
    e.ab        = ab;
    e.sel_after = 4'(w);
    return e;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic do_packet(input logic [15:0] mask, input logic [47:0] pv, input logic [63:0] dv,
                           input int hold, input bit ab);
    int          w;
    logic [15:0] wb;
    w  = ref_pick(mask, pv);
    wb = 16'h1 << w;
    exp_q.push_back(mk_exp(w, dv, ab));
    ready       = mask;
    eop         = '0;
    priority_in = pv;
    des_port_in = dv;
    step();
    for (int k = 0; k < hold; k++) begin
      ready       = 16'($urandom) | wb;
      eop         = 16'($urandom) & ~wb;
      priority_in = 48'({$urandom, $urandom});
      des_port_in = {$urandom, $urandom};
      step();
    end
    if (ab) begin
      ready = 16'($urandom) & ~wb;
      eop   = 16'($urandom) & ~wb;
    end else begin
      ready = 16'($urandom);
      eop   = 16'($urandom) | wb;
    end
    step();
    model_last = w;
    ready = 16'($urandom);
    eop   = 16'($urandom);
    step();
    ready = '0;
    eop   = '0;
  endtask

  initial begin : monitor
    logic [15:0] prev;
    exp_t        cur;
    prev = '0;
    cur  = '{sel: 4'd0, des: 4'd0, ab: 1'b0, sel_after: 4'd0};
    forever begin
      @(negedge clk);
      if (grant != 0 && prev == 0) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_grant: got %0h expected 0", grant);
        end else begin
          cur = exp_q.pop_front();
          chk("select", select, cur.sel);
          chk("grant_onehot", grant, 16'h1 << cur.sel);
          chk("grant_des_port", grant_des_port, cur.des);
          chk("busy_on", busy, 1'b1);
        end
      end else if (grant != 0) begin
        chk("grant_stable", grant, prev);
        chk("busy_hold", busy, 1'b1);
      end else if (prev != 0) begin
        chk("abort_on_release", abort, cur.ab);
        chk("select_retained", select, cur.sel_after);
        chk("busy_off", busy, 1'b0);
      end else begin
        chk("no_stray_abort", abort, 1'b0);
      end
      prev = grant;
    end
  end

  initial begin : driver
    logic [15:0] mask;
    logic [47:0] pv;
    int          w;
    rst         = 1'b1;
    ready       = '0;
    eop         = '0;
    priority_in = '0;
    des_port_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_grant", grant, 16'h0);
    chk("rst_select", select, 4'h0);
    chk("rst_des", grant_des_port, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_abort", abort, 1'b0);
    step();

    // wrap-around fairness between ports 0 and 15 at equal priority
    repeat (3) do_packet(16'h8001, 48'(1) | (48'(1) << 45), {$urandom, $urandom}, 1, 1'b0);
    do_packet(16'h0001, 48'(3), {$urandom, $urandom}, 0, 1'b0);
    do_packet(16'h0090, (48'(2) << 12) | (48'(5) << 21), {$urandom, $urandom}, 2, 1'b0);
    do_packet(16'h0010, (48'(2) << 12), {$urandom, $urandom}, 1, 1'b0);
    do_packet(16'h0004, 48'({$urandom, $urandom}), {$urandom, $urandom}, 4, 1'b0);
    do_packet(16'h0020, 48'({$urandom, $urandom}), {$urandom, $urandom}, 2, 1'b1);

    // reset in the middle of a grant: immediate release, no abort, select cleared
    mask = 16'h0400;
    pv   = 48'({$urandom, $urandom});
    w    = ref_pick(mask, pv);
    exp_q.push_back('{sel: 4'(w), des: 4'd0, ab: 1'b0, sel_after: 4'd0});
    exp_q[exp_q.size()-1].des = 4'(des_port_in[w*4 +: 4]);
    ready = mask;
    priority_in = pv;
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    ready = '0;
    model_last = 15;
    chk("rst_in_grant_busy", busy, 1'b0);
    step();

    mask = 16'h0200;
    pv   = 48'({$urandom, $urandom});
    w    = ref_pick(mask, pv);
`ifdef WRITE_SCHED_TIMEOUT_EN
    exp_q.push_back(mk_exp(w, des_port_in, 1'b1));
    ready = mask;
    priority_in = pv;
    step();
    repeat (7) step();
    chk("tmo_still_held", grant, 16'h1 << w);
    step();
    chk("tmo_released", grant, 16'h0);
    chk("tmo_abort", abort, 1'b1);
    model_last = w;
    ready = '0;
    step();
`else
    exp_q.push_back(mk_exp(w, des_port_in, 1'b0));
    ready = mask;
    priority_in = pv;
    step();
    repeat (99) step();
    chk("held_at_100", grant, 16'h1 << w);
    eop = mask;
    step();
    chk("late_release", grant, 16'h0);
    model_last = w;
    ready = '0;
    eop   = '0;
    step();
`endif

    for (int n = 0; n < 60; n++) begin
      mask = 16'($urandom) | (16'h1 << $urandom_range(0, 15));
      pv   = 48'({$urandom, $urandom});
      if ($urandom_range(0, 1) == 1) pv = pv & {16{3'b001}};
      do_packet(mask, pv, {$urandom, $urandom}, $urandom_range(0, 5), $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) step();
    end

    repeat (3) step();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
